miso_pop_ctrl: RTL and testbench

MISO_POP_CTRL -- requirements
Module: miso_pop_ctrl

---
 rtl/miso_pop_ctrl_pkg.sv | 17 +
 rtl/miso_pop_ctrl.sv | 151 +++++++++++++++
 tb/tb_miso_pop_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miso_pop_ctrl_pkg.sv
// Shared constants for the MISO FIFO pop controller and FIFO users:
// precision mode encodings and the pop-controller state enum.
package miso_pop_ctrl_pkg;

  localparam logic [1:0] P_MODE_8X8 = 2'b00;
  localparam logic [1:0] P_MODE_4X4 = 2'b01;
  localparam logic [1:0] P_MODE_2X2 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_DRAIN,
    ST_REWIND,
    ST_DONE
  } pop_state_e;

endpackage

// File: rtl/miso_pop_ctrl.sv
// Multi-pass MISO FIFO drain controller with pointer rewind between passes.
// Optional blocked-pop counter enabled by MISO_POP_CTRL_STALL_CNT_EN.
module miso_pop_ctrl
  import miso_pop_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int PASS_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_p_mode,
  input  logic [CNT_W-1:0]  i_num_elems,
  input  logic [PASS_W-1:0] i_num_passes,
  input  logic              i_stall,
  input  logic              i_fifo_empty,
  input  logic              i_pop_valid,
  output logic              o_pop_en,
  output logic              o_r_pointer_reset,
  output logic [1:0]        o_p_mode,
  output logic              o_busy,
  output logic              o_done,
  output logic [PASS_W-1:0] o_pass_idx,
  output logic [15:0]       o_stall_cycles
);

  localparam logic [CNT_W+1:0] ONE_X   = 1;
  localparam logic [CNT_W+1:0] THREE_X = 3;
  localparam logic [PASS_W:0]  ONE_P   = 1;

  pop_state_e        state;
  logic [CNT_W-1:0]  pops_per_pass;
  logic [CNT_W-1:0]  remaining;
  logic [PASS_W-1:0] passes;
  logic              accept;
  logic              blocked;
  logic              last_pass;
  logic              pop_valid_unused;

  // Elements packed per FIFO word grow as precision shrinks.
  function automatic logic [CNT_W-1:0] pops_for(
    input logic [1:0]       mode,
    input logic [CNT_W-1:0] n
  );
    logic [CNT_W+1:0] x;
    x = {2'b00, n};
    unique case (mode)
      P_MODE_4X4: pops_for = CNT_W'((x + ONE_X) >> 1);
      P_MODE_2X2: pops_for = CNT_W'((x + THREE_X) >> 2);
      default:    pops_for = n;
    endcase
  endfunction

  assign pop_valid_unused = i_pop_valid;

  assign accept = (state == ST_IDLE) && i_start && !i_abort;

  assign blocked = i_fifo_empty || i_stall;

  assign last_pass = !(({1'b0, o_pass_idx} + ONE_P) < {1'b0, passes});

  assign o_pop_en = (state == ST_POP) && (remaining != '0)
                    && !blocked && !i_abort && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= ST_IDLE;
      pops_per_pass     <= '0;
      remaining         <= '0;
      passes            <= '0;
      o_p_mode          <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_r_pointer_reset <= 1'b0;
      o_pass_idx        <= '0;
    end else begin
      o_done            <= 1'b0;
      o_r_pointer_reset <= 1'b0;
      if (state != ST_IDLE && i_abort) begin
        state      <= ST_IDLE;
        o_busy     <= 1'b0;
        o_pass_idx <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (accept) begin
              o_p_mode      <= i_p_mode;
              passes        <= i_num_passes;
              pops_per_pass <= pops_for(i_p_mode, i_num_elems);
              remaining     <= pops_for(i_p_mode, i_num_elems);
              o_busy        <= 1'b1;
              if (i_num_elems != '0 && i_num_passes != '0) begin
                state <= ST_POP;
              end else begin
                state  <= ST_DONE;
                o_done <= 1'b1;
              end
            end
          end
          ST_POP: begin
            if (o_pop_en) begin
              remaining <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (last_pass) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state             <= ST_REWIND;
              o_r_pointer_reset <= 1'b1;
            end
          end
          ST_REWIND: begin
            state      <= ST_POP;
            remaining  <= pops_per_pass;
            o_pass_idx <= o_pass_idx + PASS_W'(1);
          end
          ST_DONE: begin
            state      <= ST_IDLE;
            o_busy     <= 1'b0;
            o_pass_idx <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MISO_POP_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (state == ST_POP && remaining != '0 && blocked
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_stall_cycles = stall_cnt;
`else
  assign o_stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_miso_pop_ctrl.sv
// Self-checking bench for miso_pop_ctrl: directed scenarios plus
// randomized jobs against a precomputed per-job timeline model.
module tb_miso_pop_ctrl;

  localparam int CNT_W  = 6;
  localparam int PASS_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic              i_abort;
  logic [1:0]        i_p_mode;
  logic [CNT_W-1:0]  i_num_elems;
  logic [PASS_W-1:0] i_num_passes;
  logic              i_stall;
  logic              i_fifo_empty;
  logic              i_pop_valid;
  logic              o_pop_en;
  logic              o_r_pointer_reset;
  logic [1:0]        o_p_mode;
  logic              o_busy;
  logic              o_done;
  logic [PASS_W-1:0] o_pass_idx;
  logic [15:0]       o_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // {empty, stall} per cycle of the current job, cycle 0 = start
  logic [1:0] blk [0:511];

  always #5 i_clk = ~i_clk;

  miso_pop_ctrl #(.CNT_W(CNT_W), .PASS_W(PASS_W)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_p_mode          (i_p_mode),
    .i_num_elems       (i_num_elems),
    .i_num_passes      (i_num_passes),
    .i_stall           (i_stall),
    .i_fifo_empty      (i_fifo_empty),
    .i_pop_valid       (i_pop_valid),
    .o_pop_en          (o_pop_en),
    .o_r_pointer_reset (o_r_pointer_reset),
    .o_p_mode          (o_p_mode),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_pass_idx        (o_pass_idx),
    .o_stall_cycles    (o_stall_cycles)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_stall      = 1'b0;
    i_fifo_empty = 1'b0;
    i_pop_valid  = 1'b0;
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 512; i++) blk[i] = 2'b00;
  endtask

  task automatic fill_blk(input int pct);
    for (int i = 0; i < 512; i++) begin
      if (i > 0 && i < 400 && $urandom_range(0, 99) < pct)
        blk[i] = 2'($urandom_range(1, 3));
      else
        blk[i] = 2'b00;
    end
  endtask

  function automatic int need_for(input int mode, input int elems);
    if (mode == 1) return (elems + 1) / 2;
    if (mode == 2) return (elems + 3) / 4;
    return elems;
  endfunction

  task automatic run_job(input string tag, input logic [1:0] mode,
                         input int elems, input int passes,
                         input bit noise);
    int need, c, stalls, exp_done, exp_pops, exp_st, exp_max;
    int pops, rptrs, dones, done_at, pass0, max_pass;
    logic [63:0] exp_mask, exp_rmask, pop_mask, rptr_mask;
    logic [1:0] seen_mode;
    need = need_for(mode, elems);
    exp_mask = '0; exp_rmask = '0;
    stalls = 0; exp_pops = 0;
    if (elems == 0 || passes == 0) begin
      exp_done = 1;
    end else begin
      c = 1;
      for (int p = 0; p < passes; p++) begin
        int got;
        got = 0;
        while (got < need) begin
          if (blk[c] != 2'b00) stalls++;
          else begin
            got++;
            exp_pops++;
            if (c < 64) exp_mask[c] = 1'b1;
          end
          c++;
        end
        c++;
        if (p < passes - 1) begin
          if (c < 64) exp_rmask[c] = 1'b1;
          c++;
        end
      end
      exp_done = c;
    end
`ifdef MISO_POP_CTRL_STALL_CNT_EN
    exp_st = stalls;
`else
    exp_st = 0;
`endif
    exp_max = (exp_pops > 0) ? passes - 1 : 0;
    pops = 0; rptrs = 0; dones = 0; done_at = -1;
    pass0 = 0; max_pass = 0;
    pop_mask = '0; rptr_mask = '0; seen_mode = 2'bxx;

    i_start      = 1'b1;
    i_p_mode     = mode;
    i_num_elems  = CNT_W'(elems);
    i_num_passes = PASS_W'(passes);
    {i_fifo_empty, i_stall} = blk[0];
    @(negedge i_clk);
    for (int cy = 1; cy <= exp_done + 1; cy++) begin
      i_start = noise && cy >= 2 && cy <= exp_done
                && $urandom_range(0, 7) == 0;
      {i_fifo_empty, i_stall} = blk[cy];
      if (noise) begin
        i_p_mode     = 2'($urandom);
        i_num_elems  = CNT_W'($urandom);
        i_num_passes = PASS_W'($urandom);
        i_pop_valid  = 1'($urandom);
      end
      #1;
      if (cy == 1) seen_mode = o_p_mode;
      if (o_pop_en) begin
        pops++;
        if (cy < 64) pop_mask[cy] = 1'b1;
        if (o_pass_idx == 0) pass0++;
        if (int'(o_pass_idx) > max_pass) max_pass = int'(o_pass_idx);
      end
      if (o_r_pointer_reset) begin
        rptrs++;
        if (cy < 64) rptr_mask[cy] = 1'b1;
      end
      if (o_done) begin
        dones++;
        done_at = cy;
      end
      @(negedge i_clk);
    end
    idle_inputs();
    #1;
    check({tag, ".pops"}, 64'(pops), 64'(exp_pops));
    check({tag, ".pop_mask"}, pop_mask, exp_mask);
    check({tag, ".rptr_mask"}, rptr_mask, exp_rmask);
    check({tag, ".rptr_cnt"}, 64'(rptrs),
          64'((exp_pops > 0) ? passes - 1 : 0));
    check({tag, ".done_cnt"}, 64'(dones), 64'd1);
    check({tag, ".done_at"}, 64'(done_at), 64'(exp_done));
    check({tag, ".pass0_pops"}, 64'(pass0),
          64'((exp_pops > 0) ? need : 0));
    check({tag, ".max_pass"}, 64'(max_pass), 64'(exp_max));
    check({tag, ".p_mode"}, 64'(seen_mode), 64'(mode));
    check({tag, ".stall_cycles"}, 64'(o_stall_cycles), 64'(exp_st));
    check({tag, ".busy_end"}, 64'(o_busy), 64'd0);
    check({tag, ".pass_idx_end"}, 64'(o_pass_idx), 64'd0);
    @(negedge i_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    i_rst        = 1'b1;
    i_p_mode     = 2'b11;
    i_num_elems  = 6'd7;
    i_num_passes = 4'd2;
    i_start      = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst.busy", 64'(o_busy), 64'd0);
    check("rst.done", 64'(o_done), 64'd0);
    check("rst.rptr", 64'(o_r_pointer_reset), 64'd0);
    check("rst.pass_idx", 64'(o_pass_idx), 64'd0);
    check("rst.p_mode", 64'(o_p_mode), 64'd0);
    check("rst.stall", 64'(o_stall_cycles), 64'd0);
    check("rst.pop_en", 64'(o_pop_en), 64'd0);
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    #1;
    check("post_rst.busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);

    clear_blk();
    run_job("8x8_e5_p1", 2'b00, 5, 1, 1'b0);
    run_job("4x4_e5_p2", 2'b01, 5, 2, 1'b0);
    clear_blk();
    for (int i = 2; i <= 5; i++) blk[i] = 2'b01;
    run_job("2x2_e9_stall", 2'b10, 9, 1, 1'b0);
    clear_blk();
    run_job("e0_p3", 2'b00, 0, 3, 1'b0);
    run_job("e4_p0", 2'b01, 4, 0, 1'b0);
    run_job("mode11_e3_p2", 2'b11, 3, 2, 1'b0);
    for (int i = 5; i <= 9; i++) blk[i] = 2'b10;
    run_job("4x4_empty", 2'b01, 12, 1, 1'b0);

    // abort in the middle of the second pop
    clear_blk();
    i_start = 1'b1; i_p_mode = 2'b00;
    i_num_elems = 6'd8; i_num_passes = 4'd1;
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    check("abort.first_pop", 64'(o_pop_en), 64'd1);
    @(negedge i_clk);
    i_abort = 1'b1;
    #1;
    check("abort.pop_gated", 64'(o_pop_en), 64'd0);
    @(negedge i_clk);
    i_abort = 1'b0;
    #1;
    check("abort.busy", 64'(o_busy), 64'd0);
    check("abort.pass_idx", 64'(o_pass_idx), 64'd0);
    check("abort.done", 64'(o_done), 64'd0);
    check("abort.pop_en", 64'(o_pop_en), 64'd0);
    @(negedge i_clk);
    #1;
    check("abort.done_later", 64'(o_done), 64'd0);
    @(negedge i_clk);
    run_job("after_abort", 2'b00, 8, 1, 1'b0);

    // start and abort together while idle
    i_start = 1'b1; i_abort = 1'b1;
    i_num_elems = 6'd3; i_num_passes = 4'd1;
    @(negedge i_clk);
    idle_inputs();
    #1;
    check("start_abort.busy", 64'(o_busy), 64'd0);
    check("start_abort.pop_en", 64'(o_pop_en), 64'd0);
    @(negedge i_clk);

    // reset while rewinding
    i_start = 1'b1; i_p_mode = 2'b01;
    i_num_elems = 6'd2; i_num_passes = 4'd2;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("rew.rptr_before", 64'(o_r_pointer_reset), 64'd1);
    i_rst = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_start = 1'b0;
    #1;
    check("rew_rst.rptr", 64'(o_r_pointer_reset), 64'd0);
    check("rew_rst.busy", 64'(o_busy), 64'd0);
    check("rew_rst.pass_idx", 64'(o_pass_idx), 64'd0);
    check("rew_rst.p_mode", 64'(o_p_mode), 64'd0);
    check("rew_rst.done", 64'(o_done), 64'd0);
    check("rew_rst.pop_en", 64'(o_pop_en), 64'd0);
    check("rew_rst.stall", 64'(o_stall_cycles), 64'd0);
    @(negedge i_clk);
    #1;
    check("rew_rst.rptr_next", 64'(o_r_pointer_reset), 64'd0);
    check("rew_rst.busy_next", 64'(o_busy), 64'd0);
    @(negedge i_clk);

    for (int j = 0; j < 30; j++) begin
      fill_blk(25);
      run_job($sformatf("rand%0d", j), 2'($urandom),
              int'($urandom_range(0, 20)),
              int'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
